// File: rtl/mul32_col_accum_yjy.sv
// -----------------------------------------------------------------------------
// mul32_col_accum_yjy
//
// Byte-serial column accumulator for a 32x32 unsigned multiply. Each column
// of partial products arrives as a 16-bit sum plus an 8-bit carry. The carry
// chain is resolved one column per accepted beat, so the full 64-bit product
// is assembled after NUM_COLS beats. The product is then held on a
// valid/ready output port until the consumer takes it.
//
// Parameters:
//   NUM_COLS     columns per product. Only 7 is supported, which is the value
//                for 32x32 with 8-bit digits.
//
// Ports:
//   clk          clock. All state updates on the rising edge.
//   rstn         asynchronous active-low reset.
//   in_valid     a column beat is present.
//   in_ready     block accepts a column this cycle (ACCUM state).
//   in_sum       column sum, low 16 bits.
//   in_carry     column carry, weight 2^16 relative to the column.
//   out_valid    assembled product available (DONE state).
//   out_ready    consumer takes the product.
//   out_product  assembled 64-bit product, held stable while out_valid.
//   out_ovf      result exceeded 64 bits. This is only built when
//                MUL32_COL_ACCUM_OVF_CHECK_EN is defined; otherwise it is
//                tied to 0.
//
// Optional feature macro: MUL32_COL_ACCUM_OVF_CHECK_EN
// -----------------------------------------------------------------------------
module mul32_col_accum_yjy #(
  parameter int NUM_COLS = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sum,
  input  logic [7:0]  in_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        out_ovf
);

  localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [25:0] res_q, res_d;
  logic [63:0] prod_q, prod_d;
  logic [25:0] r_new;

  // Carry-chain step. The residue keeps everything above the byte already
  // committed to the product. Shift that byte out and add the next column,
  // which sits 8 bits higher. The result stays below 2^25, so 26 bits are
  // enough and no truncation happens before the final byte.
  function automatic logic [25:0] fold_col(input logic [25:0] r,
                                           input logic [23:0] v);
    return (r >> 8) + 26'(v);
  endfunction

  assign r_new = fold_col(res_q, {in_carry, in_sum});

`ifdef MUL32_COL_ACCUM_OVF_CHECK_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    prod_d  = prod_q;
`ifdef MUL32_COL_ACCUM_OVF_CHECK_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          res_d = r_new;
          // Commit the low byte of the residue into this column's byte lane.
          for (int k = 0; k < NUM_COLS; k++) begin
            if (cnt_q == 3'(k)) begin
              prod_d[8*k +: 8] = r_new[7:0];
            end
          end
          if (cnt_q == LAST_COL) begin
            // The last column also supplies the top byte of the product.
            prod_d[8*NUM_COLS +: 8] = r_new[15:8];
            cnt_d   = 3'd0;
            state_d = ST_DONE;
`ifdef MUL32_COL_ACCUM_OVF_CHECK_EN
            ovf_d   = |r_new[25:16];
`endif
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          res_d   = '0;
          prod_d  = '0;
          state_d = ST_ACCUM;
`ifdef MUL32_COL_ACCUM_OVF_CHECK_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_ACCUM;
      cnt_q   <= 3'd0;
      res_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      prod_q  <= prod_d;
    end
  end

`ifdef MUL32_COL_ACCUM_OVF_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  // Handshake flags decode registered state only. They have no combinational
  // path from in_valid or out_ready.
  assign in_ready    = (state_q == ST_ACCUM);
  assign out_valid   = (state_q == ST_DONE);
  assign out_product = prod_q;

endmodule

// File: tb/tb_mul32_col_accum_yjy.sv
module tb_mul32_col_accum_yjy;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic [7:0]  in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  mul32_col_accum_yjy #(.NUM_COLS(7)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .in_carry    (in_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_ovf     (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the product is the plain weighted sum of the columns,
  // sum(v_k * 256^k), computed wide. The low 64 bits form the product, and
  // anything above bit 63 is overflow.
  task automatic model(input logic [23:0] cols [7], output logic [63:0] p, output logic o);
    logic [127:0] s;
    s = '0;
    for (int k = 0; k < 7; k++) s = s + (128'(cols[k]) << (8 * k));
    p = s[63:0];
`ifdef MUL32_COL_ACCUM_OVF_CHECK_EN
    o = |s[127:64];
`else
    o = 1'b0;
`endif
  endtask

  task automatic send_col(input logic [23:0] v, input int gap);
    int guard;
    guard = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("send_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    {in_carry, in_sum} = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sum   = 16'($urandom);
    in_carry = 8'($urandom);
  endtask

  task automatic send_all(input logic [23:0] cols [7], input int gap);
    for (int k = 0; k < 7; k++) send_col(cols[k], gap);
  endtask

  task automatic get_result(input string tag, input logic [63:0] ep, input logic eo,
                            input int hold, input bit immediate);
    int guard;
    guard = 0;
    @(negedge clk);
    if (immediate) check({tag, "_latency"}, out_valid, 1'b1);
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_product"}, out_product, ep);
    check({tag, "_ovf"}, out_ovf, eo);
    check({tag, "_in_ready_done"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_sum   = 16'($urandom);
      in_carry = 8'($urandom);
      @(negedge clk);
      check({tag, "_bp_in_ready"}, in_ready, 1'b0);
      check({tag, "_bp_valid"}, out_valid, 1'b1);
      check({tag, "_bp_product"}, out_product, ep);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_hs_in_ready"}, in_ready, 1'b1);
    check({tag, "_hs_valid"}, out_valid, 1'b0);
    check({tag, "_hs_cleared"}, out_product, 64'h0);
  endtask

  initial begin
    logic [23:0] cols [7];
    logic [23:0] sq   [7];
    logic [23:0] zero [7];
    logic [63:0] ep;
    logic        eo;

    sq = '{24'h00FE01, 24'h01FC02, 24'h02FA03, 24'h03F804, 24'h02FA03, 24'h01FC02, 24'h00FE01};
    zero = '{default: 24'h0};

    rstn = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_product", out_product, 64'h0);
    check("rst_ovf", out_ovf, 1'b0);
    rstn = 1'b1;

    // All-zero columns, full rate
    send_all(zero, 0);
    get_result("zero", 64'h0, 1'b0, 0, 1'b1);

    // 0xFFFFFFFF squared, full rate, with the model checked against the known answer
    model(sq, ep, eo);
    check("sq_model", ep, 64'hFFFFFFFE00000001);
    send_all(sq, 0);
    get_result("sq", 64'hFFFFFFFE00000001, 1'b0, 0, 1'b1);

    // Back-pressure: 5 stalled cycles with junk on the input, then a fresh product
    send_all(sq, 0);
    get_result("bp", 64'hFFFFFFFE00000001, 1'b0, 5, 1'b1);
    for (int k = 0; k < 7; k++) cols[k] = 24'($urandom_range(0, 24'hFFFF));
    model(cols, ep, eo);
    send_all(cols, 0);
    get_result("bp_next", ep, eo, 0, 1'b1);

    // Bubbles: 2-cycle gaps between beats
    cols = zero; cols[0] = 24'h1; cols[1] = 24'h1;
    send_all(cols, 2);
    get_result("bubble", 64'h0000000000000101, 1'b0, 0, 1'b0);

    // Reset after 3 accepted columns
    for (int k = 0; k < 3; k++) send_col(24'($urandom), 0);
    #2 rstn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_product", out_product, 64'h0);
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid2", out_valid, 1'b0);
    rstn = 1'b1;
    send_all(sq, 0);
    get_result("midrst_sq", 64'hFFFFFFFE00000001, 1'b0, 0, 1'b1);

    // Reset while a product is being held
    send_all(sq, 0);
    @(negedge clk);
    check("heldrst_pre_valid", out_valid, 1'b1);
    #1 rstn = 1'b0;
    #1;
    check("heldrst_valid", out_valid, 1'b0);
    check("heldrst_product", out_product, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    cols = zero; cols[0] = 24'h0000AB;
    send_all(cols, 0);
    get_result("heldrst_next", 64'hAB, 1'b0, 0, 1'b1);

    // Overflow: only column 6 non-zero, at its maximum value
    cols = zero; cols[6] = 24'hFFFFFF;
    model(cols, ep, eo);
    check("ovf_model", ep, 64'hFFFF000000000000);
    send_all(cols, 0);
`ifdef MUL32_COL_ACCUM_OVF_CHECK_EN
    get_result("ovf", 64'hFFFF000000000000, 1'b1, 2, 1'b1);
`else
    get_result("ovf", 64'hFFFF000000000000, 1'b0, 2, 1'b1);
`endif

    // Randomised products with random gaps and random stall lengths
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 7; k++) cols[k] = 24'($urandom);
      model(cols, ep, eo);
      for (int k = 0; k < 7; k++) send_col(cols[k], int'($urandom_range(0, 2)));
      get_result("rand", ep, eo, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul32_col_accum_yjy.md
# mul32_col_accum_yjy

Byte-serial column accumulator that turns seven per-column partial-product sums into the final 64-bit product of a 32x32 unsigned multiply. Sits directly downstream of the middle-term partial-product stages. Each stage delivers one column as a 16-bit sum plus an 8-bit carry, which this block consumes under a valid/ready handshake. The block resolves the carry chain one column per beat and presents the assembled product on a held valid/ready output port.

## Interface
Parameters:
- NUM_COLS, 7, columns per product; fixed for 32x32 with 8-bit digits. Any other value is unsupported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  column beat present.
- in_ready  out  1  block accepts a column this cycle.
- in_sum  in  16  column sum, low part.
- in_carry  in  8  column carry, weight 2^16 relative to the column.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes the product.
- out_product  out  64  assembled product.
- out_ovf  out  1  result exceeded 64 bits. Only meaningful with the macro described under Configuration.

## Operation
- Column value: v = {in_carry, in_sum} (24 bits). Column k carries weight 2^(8k), and columns arrive in order k = 0..6.
- State: 26-bit residue r, 3-bit column counter cnt, 64-bit product register P, FSM {ACCUM, DONE}.
- ACCUM:
  - in_ready = 1.
  - On accept (in_valid & in_ready): r_new = (r >> 8) + v, and P[8k+7:8k] = r_new[7:0] with k = cnt.
  - If cnt == 6: also P[63:56] = r_new[15:8], cnt -> 0, and the FSM goes to DONE.
  - Otherwise cnt increments.
- DONE:
  - in_ready = 0 and out_valid = 1. out_product = P, held stable.
  - On out_ready: r -> 0, P -> 0, out_ovf -> 0, and the FSM returns to ACCUM.
- Accumulation is unsigned throughout. r never exceeds 2^25, so no truncation occurs before the final byte.
- Reset values: state ACCUM, cnt 0, r 0, P 0. in_ready = 1, out_valid = 0, out_product = 0, out_ovf = 0.

## Timing
- Throughput: one column per cycle while in_valid is held high. Gaps in in_valid stall the block without losing state.
- Latency: out_valid rises on the clock edge that accepts column 6 and is visible the next cycle. At full rate that is 7 cycles from the first beat.
- No bypass: in_ready returns to 1 in the cycle after the out_valid & out_ready handshake. Minimum period is 8 cycles per product.
- in_ready and out_valid are registered-state decodes, with no combinational path from in_valid or out_ready.
- Inputs presented while in_ready = 0 are ignored.
- Reset mid-operation:
  - rstn low asynchronously clears all state, including a partial accumulation or a held product.
  - The first beat after release is treated as column 0.

## Configuration
- MUL32_COL_ACCUM_OVF_CHECK_EN:
  - Defined: on accepting column 6, out_ovf is set if r_new[25:16] != 0. It is held through DONE and cleared on the output handshake or on reset.
  - Undefined: no check logic is built, out_ovf is tied to 0, and bits above the product are silently dropped.

## Test plan
- All seven columns zero -> out_valid after 7th beat, out_product = 0x0000000000000000, out_ovf = 0.
- 0xFFFFFFFF squared: columns 0x00FE01, 0x01FC02, 0x02FA03, 0x03F804, 0x02FA03, 0x01FC02, 0x00FE01 -> out_product = 0xFFFFFFFE00000001.
- Back-pressure:
  - Stimulus: same stimulus as the squared case, then out_ready held low 5 cycles, with in_valid held high and varying in_sum/in_carry throughout.
  - Response: in_ready = 0 and out_product stable for all 5 cycles. After out_ready rises, in_ready = 1 the following cycle and the next result is unaffected by the ignored beats.
- Bubbles: column 0 = 0x000001, column 1 = 0x000001, others 0, with 2-cycle in_valid gaps between beats -> out_product = 0x0000000000000101.
- Reset mid-operation:
  - Stimulus: assert rstn low after 3 accepted columns, then send a full 0xFFFFFFFF-squared sequence.
  - Response: out_valid = 0 during reset and the result equals 0xFFFFFFFE00000001.
- Overflow:
  - Stimulus: columns 0..5 = 0, column 6 = carry 0xFF, sum 0xFFFF.
  - Macro defined: out_ovf = 1 and out_product = 0xFFFF000000000000.
  - Macro undefined: out_ovf = 0 and the same out_product.
